// File: rtl/audio_output_if.sv
// rtl/audio_output_if.sv - sample/mute inputs and pulse-density outputs of the stereo audio DAC
interface audio_output_if #(
   parameter int DW = 10
);
   logic [DW-1:0] i_dt_l;
   logic [DW-1:0] i_dt_r;
   logic          i_dt_en;
   logic          i_mute;
   logic          o_dac_l;
   logic          o_dac_r;
   logic          o_muted;

   modport master (
      output i_dt_l, i_dt_r, i_dt_en, i_mute,
      input  o_dac_l, o_dac_r, o_muted
   );

   modport slave (
      input  i_dt_l, i_dt_r, i_dt_en, i_mute,
      output o_dac_l, o_dac_r, o_muted
   );
endinterface

// File: rtl/audio_output.sv
// rtl/audio_output.sv - stereo first-order delta-sigma DAC with soft mute ramping to midscale
module audio_output #(
   parameter int DW        = 10,
   parameter int RAMP_STEP = 4
) (
   input logic           i_clk,
   input logic           i_rst_n,
   audio_output_if.slave bus
);
   localparam logic [DW-1:0] MID  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW:0]   STEP = (DW+1)'(RAMP_STEP);

   typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DN} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] eff_l, eff_r, eff_l_nxt, eff_r_nxt;
   logic [DW-1:0] acc_l, acc_r;
   logic [DW-1:0] hold_l, hold_r;
   logic [DW-1:0] tgt_l, tgt_r;
   logic [DW-1:0] up_l, up_r, dn_l, dn_r;
   logic          dac_l, dac_r;

   // Move cur by STEP toward tgt, landing exactly on tgt once within reach.
   function automatic logic [DW-1:0] step_to(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
      logic signed [DW:0] diff;
      logic [DW:0]        mag;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
      if (mag <= STEP)
         step_to = tgt;
      else if (diff[DW])
         step_to = cur - STEP[DW-1:0];
      else
         step_to = cur + STEP[DW-1:0];
   endfunction

   always_comb begin
      tgt_l     = bus.i_dt_en ? bus.i_dt_l : hold_l;
      tgt_r     = bus.i_dt_en ? bus.i_dt_r : hold_r;
      up_l      = step_to(eff_l, tgt_l);
      up_r      = step_to(eff_r, tgt_r);
      dn_l      = step_to(eff_l, MID);
      dn_r      = step_to(eff_r, MID);
      state_nxt = state;
      eff_l_nxt = eff_l;
      eff_r_nxt = eff_r;
      if (bus.i_dt_en) begin
         unique case (state)
            RUN: begin
               if (bus.i_mute) begin
                  state_nxt = RAMP_DN;
               end else begin
                  eff_l_nxt = bus.i_dt_l;
                  eff_r_nxt = bus.i_dt_r;
               end
            end
            RAMP_DN: begin
               if (!bus.i_mute) begin
                  state_nxt = RAMP_UP;
               end else begin
                  eff_l_nxt = dn_l;
                  eff_r_nxt = dn_r;
                  if (dn_l == MID && dn_r == MID)
                     state_nxt = MUTED;
               end
            end
            MUTED: begin
               eff_l_nxt = MID;
               eff_r_nxt = MID;
               if (!bus.i_mute)
                  state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
               if (bus.i_mute) begin
                  state_nxt = RAMP_DN;
               end else begin
                  eff_l_nxt = up_l;
                  eff_r_nxt = up_r;
                  if (up_l == tgt_l && up_r == tgt_r)
                     state_nxt = RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= MUTED;
         eff_l  <= MID;
         eff_r  <= MID;
         hold_l <= MID;
         hold_r <= MID;
         acc_l  <= '0;
         acc_r  <= '0;
         dac_l  <= 1'b0;
         dac_r  <= 1'b0;
      end else begin
         state <= state_nxt;
         eff_l <= eff_l_nxt;
         eff_r <= eff_r_nxt;
         if (bus.i_dt_en) begin
            hold_l <= bus.i_dt_l;
            hold_r <= bus.i_dt_r;
         end
         // Carry out of the accumulator is the pulse-density bit.
         {dac_l, acc_l} <= {1'b0, acc_l} + {1'b0, eff_l};
         {dac_r, acc_r} <= {1'b0, acc_r} + {1'b0, eff_r};
      end
   end

   assign bus.o_dac_l = dac_l;
   assign bus.o_dac_r = dac_r;
   assign bus.o_muted = (state == MUTED);
endmodule

// File: tb/tb_audio_output.sv
// tb/tb_audio_output.sv - randomized self-checking bench for audio_output against a behavioural model
module tb_audio_output;
   localparam int DW   = 10;
   localparam int FULL = 1 << DW;
   localparam int MID  = FULL / 2;
   localparam int STEP = 4;

   localparam int MODE_PLAY     = 0;
   localparam int MODE_FADE_OUT = 1;
   localparam int MODE_SILENT   = 2;
   localparam int MODE_FADE_IN  = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;

   int m_acc_l, m_acc_r, m_eff_l, m_eff_r, m_dac_l, m_dac_r, m_mode;

   audio_output_if #(.DW(DW)) bus();

   audio_output #(.DW(DW), .RAMP_STEP(STEP)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int step_to(input int cur, input int tgt);
      int d = tgt - cur;
      if (d <= STEP && d >= -STEP) return tgt;
      return (d > 0) ? cur + STEP : cur - STEP;
   endfunction

   // Reference: bitstream from a modulo-FULL running sum; levels steered only at strobes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc_l <= 0;   m_acc_r <= 0;
         m_eff_l <= MID; m_eff_r <= MID;
         m_dac_l <= 0;   m_dac_r <= 0;
         m_mode  <= MODE_SILENT;
      end else begin
         m_dac_l <= (m_acc_l + m_eff_l >= FULL) ? 1 : 0;
         m_dac_r <= (m_acc_r + m_eff_r >= FULL) ? 1 : 0;
         m_acc_l <= (m_acc_l + m_eff_l) % FULL;
         m_acc_r <= (m_acc_r + m_eff_r) % FULL;
         if (bus.i_dt_en === 1'b1) begin
            case (m_mode)
               MODE_PLAY:
                  if (bus.i_mute) m_mode <= MODE_FADE_OUT;
                  else begin
                     m_eff_l <= int'(bus.i_dt_l);
                     m_eff_r <= int'(bus.i_dt_r);
                  end
               MODE_FADE_OUT:
                  if (!bus.i_mute) m_mode <= MODE_FADE_IN;
                  else begin
                     m_eff_l <= step_to(m_eff_l, MID);
                     m_eff_r <= step_to(m_eff_r, MID);
                     if (step_to(m_eff_l, MID) == MID && step_to(m_eff_r, MID) == MID)
                        m_mode <= MODE_SILENT;
                  end
               MODE_SILENT:
                  if (!bus.i_mute) m_mode <= MODE_FADE_IN;
               default:
                  if (bus.i_mute) m_mode <= MODE_FADE_OUT;
                  else begin
                     m_eff_l <= step_to(m_eff_l, int'(bus.i_dt_l));
                     m_eff_r <= step_to(m_eff_r, int'(bus.i_dt_r));
                     if (step_to(m_eff_l, int'(bus.i_dt_l)) == int'(bus.i_dt_l) &&
                         step_to(m_eff_r, int'(bus.i_dt_r)) == int'(bus.i_dt_r))
                        m_mode <= MODE_PLAY;
                  end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("dac_l", int'(bus.o_dac_l), m_dac_l);
         check("dac_r", int'(bus.o_dac_r), m_dac_r);
         check("muted", int'(bus.o_muted), (m_mode == MODE_SILENT) ? 1 : 0);
      end
   end

   task automatic drive(input bit en, input int l, input int r, input bit mute);
      bus.i_dt_en = en;
      bus.i_dt_l  = DW'(l);
      bus.i_dt_r  = DW'(r);
      bus.i_mute  = mute;
      @(negedge clk);
   endtask

   initial begin
      int ones_l, ones_r;
      rst_n       = 1'b0;
      bus.i_dt_en = 1'b0;
      bus.i_dt_l  = DW'(MID);
      bus.i_dt_r  = DW'(MID);
      bus.i_mute  = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_dac_l", int'(bus.o_dac_l), 0);
      check("rst_dac_r", int'(bus.o_dac_r), 0);
      check("rst_muted", int'(bus.o_muted), 1);
      check("rst_eff_l", int'(dut.eff_l), MID);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // T1: midscale alternates 0,1 from reset; unmute at midscale reaches RUN
      for (int k = 0; k < 8; k++) begin
         drive(0, MID, MID, 0);
         check("t1_alt", int'(bus.o_dac_l), k % 2);
      end
      drive(1, MID, MID, 0);
      check("t1_unmuted", int'(bus.o_muted), 0);
      drive(1, MID, MID, 0);
      drive(1, 300, 700, 0);
      check("t1_run_copy", int'(dut.eff_l), 300);

      // T2: density of the bitstream at eff 256 / 0
      repeat (300) drive(1, 256, 0, 0);
      check("t2_eff_l", int'(dut.eff_l), 256);
      ones_l = 0;
      ones_r = 0;
      for (int k = 0; k < FULL; k++) begin
         drive(0, 256, 0, 0);
         ones_l += int'(bus.o_dac_l);
         ones_r += int'(bus.o_dac_r);
      end
      check("t2_ones_l", ones_l, 256);
      check("t2_ones_r", ones_r, 0);

      // T3: full-scale ramp down with a strobe every cycle
      repeat (300) drive(1, 1023, 0, 0);
      drive(1, 1023, 0, 1);
      check("t3_eff_hold", int'(dut.eff_l), 1023);
      for (int k = 1; k <= 128; k++) begin
         drive(1, 1023, 0, 1);
         if (k == 127) begin
            check("t3_eff_l_127", int'(dut.eff_l), 515);
            check("t3_eff_r_127", int'(dut.eff_r), 508);
            check("t3_not_muted", int'(bus.o_muted), 0);
         end
      end
      check("t3_eff_l_mid", int'(dut.eff_l), MID);
      check("t3_muted", int'(bus.o_muted), 1);

      // T4: reverse mid-ramp, then ramp up to the input
      repeat (300) drive(1, 800, 224, 0);
      drive(1, 800, 224, 1);
      repeat (25) drive(1, 800, 224, 1);
      check("t4_eff_700", int'(dut.eff_l), 700);
      drive(1, 800, 224, 0);
      check("t4_reverse_hold", int'(dut.eff_l), 700);
      for (int k = 1; k <= 25; k++) begin
         drive(1, 800, 224, 0);
         if (k == 24) check("t4_eff_796", int'(dut.eff_l), 796);
      end
      check("t4_eff_800", int'(dut.eff_l), 800);
      drive(1, 900, 100, 0);
      check("t4_run_copy", int'(dut.eff_l), 900);

      // T5: mute level changes between strobes are ignored
      repeat (300) drive(1, 900, 100, 1);
      check("t5_muted", int'(bus.o_muted), 1);
      repeat (3) drive(0, 900, 100, 0);
      check("t5_still_muted", int'(bus.o_muted), 1);
      drive(0, 900, 100, 1);
      drive(1, 900, 100, 1);
      check("t5_strobe_muted", int'(bus.o_muted), 1);

      // Randomized traffic: random data, sparse and back-to-back strobes, rare mute flips
      begin
         bit mute = 1'b0;
         for (int k = 0; k < 1500; k++) begin
            int d_l, d_r;
            if ($urandom_range(0, 39) == 0) mute = ~mute;
            d_l = ($urandom_range(0, 3) == 0) ? MID + int'($urandom_range(0, 8)) - 4
                                              : int'($urandom_range(0, FULL - 1));
            d_r = int'($urandom_range(0, FULL - 1));
            drive(($urandom_range(0, 2) != 0), d_l, d_r, mute);
         end
      end

      // T6: asynchronous reset in the middle of a ramp
      repeat (300) drive(1, MID, MID, 1);
      repeat (5) drive(1, 1000, 20, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_dac_l", int'(bus.o_dac_l), 0);
      check("t6_dac_r", int'(bus.o_dac_r), 0);
      check("t6_muted", int'(bus.o_muted), 1);
      bus.i_dt_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1000, 20, 0);
      check("t6_eff_l", int'(dut.eff_l), MID);
      check("t6_eff_r", int'(dut.eff_r), MID);
      repeat (20) drive(1, 1000, 20, 0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
